// File: rtl/recon_pixel_writer_pkg.sv
// Encoder-wide constants, FSM state type and the 4x4-block position decode
// shared by every block that walks macroblocks in 4x4-block order.
package recon_pixel_writer_pkg;

  localparam int MB_SIZE  = 16;
  localparam int BLK_SIZE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] bx;
    logic [1:0] by;
  } blk_pos_t;

  // 8x8-quadrant order: even bits of blk select column, odd bits select row.
  function automatic blk_pos_t blk4_pos(input logic [3:0] blk);
    blk_pos_t p;
    p.bx = {blk[2], blk[0]};
    p.by = {blk[3], blk[1]};
    return p;
  endfunction

endpackage

// File: rtl/recon_pixel_writer_mb_scan_counter.sv
// Pixel-in-macroblock index plus macroblock column/row, stepped once per
// accepted pixel; the write-side twin of the read-side x/y stepping.
module mb_scan_counter
  import recon_pixel_writer_pkg::*;
#(
  parameter int MBS_X = 22,
  parameter int MBS_Y = 18,
  localparam int XW = (MBS_X > 1) ? $clog2(MBS_X) : 1,
  localparam int YW = (MBS_Y > 1) ? $clog2(MBS_Y) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [7:0]    o_pidx,
  output logic [XW-1:0] o_mb_x,
  output logic [YW-1:0] o_mb_y,
  output logic          o_mb_last,
  output logic          o_frame_last
);

  logic [7:0]    r_pidx;
  logic [XW-1:0] r_mb_x;
  logic [YW-1:0] r_mb_y;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_mb_last;

  assign w_x_last  = (r_mb_x == XW'(MBS_X - 1));
  assign w_y_last  = (r_mb_y == YW'(MBS_Y - 1));
  assign w_mb_last = (r_pidx == 8'hFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pidx <= '0;
      r_mb_x <= '0;
      r_mb_y <= '0;
    end else if (i_clr) begin
      r_pidx <= '0;
      r_mb_x <= '0;
      r_mb_y <= '0;
    end else if (i_adv) begin
      r_pidx <= r_pidx + 8'd1;
      // The last pixel of the frame wraps every counter back to zero.
      if (w_mb_last) begin
        if (w_x_last) begin
          r_mb_x <= '0;
          r_mb_y <= w_y_last ? '0 : r_mb_y + 1'b1;
        end else begin
          r_mb_x <= r_mb_x + 1'b1;
        end
      end
    end
  end

  assign o_pidx       = r_pidx;
  assign o_mb_x       = r_mb_x;
  assign o_mb_y       = r_mb_y;
  assign o_mb_last    = w_mb_last;
  assign o_frame_last = w_mb_last && w_x_last && w_y_last;

endmodule

// File: rtl/recon_pixel_writer.sv
// Converts reconstructed luma pixels in macroblock/4x4-block order into
// raster frame-buffer writes (one registered address/data pair per pixel).
module recon_pixel_writer
  import recon_pixel_writer_pkg::*;
#(
  parameter int FRAME_W = 352,
  parameter int FRAME_H = 288,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [PIX_W-1:0]  i_pix_in,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_mb_done,
  output logic              o_frame_done,
  output logic              o_busy,
  output state_t            o_state
);

  localparam int MBS_X = FRAME_W / MB_SIZE;
  localparam int MBS_Y = FRAME_H / MB_SIZE;
  localparam int XW    = (MBS_X > 1) ? $clog2(MBS_X) : 1;
  localparam int YW    = (MBS_Y > 1) ? $clog2(MBS_Y) : 1;

  // Handshake: a pixel is transferred on every clock where i_pix_valid and
  // o_pix_ready are both high; o_pix_ready is high exactly while in RUN and
  // the source may drop i_pix_valid at any time without losing position.
  state_t            r_state;
  logic              r_busy;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic              r_mb_done;
  logic              r_frame_done;

  logic              w_xfer;
  logic              w_clr;
  logic [7:0]        w_pidx;
  logic [XW-1:0]     w_mb_x;
  logic [YW-1:0]     w_mb_y;
  logic              w_mb_last;
  logic              w_frame_last;
  blk_pos_t          w_pos;
  logic [31:0]       w_x;
  logic [31:0]       w_y;
  logic [ADDR_W-1:0] w_addr;

  assign w_xfer = (r_state == RUN) && i_pix_valid;
  assign w_clr  = (r_state == IDLE) && i_start;

  mb_scan_counter #(
    .MBS_X (MBS_X),
    .MBS_Y (MBS_Y)
  ) u_scan (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (w_clr),
    .i_adv        (w_xfer),
    .o_pidx       (w_pidx),
    .o_mb_x       (w_mb_x),
    .o_mb_y       (w_mb_y),
    .o_mb_last    (w_mb_last),
    .o_frame_last (w_frame_last)
  );

  assign w_pos = blk4_pos(w_pidx[7:4]);

  // Products at 32 bits, then reduced to the memory address width.
  assign w_x = 32'(w_mb_x) * 32'(MB_SIZE) + 32'(w_pos.bx) * 32'(BLK_SIZE)
             + 32'(w_pidx[1:0]);
  assign w_y = 32'(w_mb_y) * 32'(MB_SIZE) + 32'(w_pos.by) * 32'(BLK_SIZE)
             + 32'(w_pidx[3:2]);
  assign w_addr = ADDR_W'(w_y * 32'(FRAME_W) + w_x);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_mb_done    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_mb_done    <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= w_addr;
            r_wr_data    <= i_pix_in;
            r_mb_done    <= w_mb_last;
            r_frame_done <= w_frame_last;
            if (w_frame_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix_ready  = r_busy;
  assign o_busy       = r_busy;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_mb_done    = r_mb_done;
  assign o_frame_done = r_frame_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_recon_pixel_writer.sv
// Bench for recon_pixel_writer on a 32x32 frame (2x2 macroblocks): an
// arithmetic raster-address model feeds an expected queue checked every cycle.
module tb_recon_pixel_writer;
  import recon_pixel_writer_pkg::*;

  localparam int FW     = 32;
  localparam int FH     = 32;
  localparam int PW     = 8;
  localparam int AW     = 10;
  localparam int NPIX   = FW * FH;
  localparam int MBX    = FW / 16;
  localparam int EW     = AW + PW + 2;
  localparam int NFR    = 6;
  localparam int BUDGET = 6000;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [PW-1:0] i_pix_in;
  logic          i_pix_valid;
  logic          o_pix_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [PW-1:0] o_wr_data;
  logic          o_mb_done;
  logic          o_frame_done;
  logic          o_busy;
  state_t        o_state;

  recon_pixel_writer #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .PIX_W   (PW),
    .ADDR_W  (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_pix_in     (i_pix_in),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_mb_done    (o_mb_done),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  bit            m_run = 1'b0;
  int            m_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] hold_addr = '0;
  logic [PW-1:0] hold_data = '0;

  // write log, one row per completed frame
  logic [AW-1:0] obs_addr[NFR][NPIX];
  bit            obs_mbd[NFR][NPIX];
  bit            obs_fd[NFR][NPIX];
  int            wr_cnt[NFR];
  int            first_cyc[NFR];
  int            last_cyc[NFR];
  bit            busy_at_fd[NFR];
  int            lf  = 0;
  int            li  = 0;
  int            cyc = 0;

  task automatic chk(input string name, input longint act, input longint want);
    n_total++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, want, $time);
    end
  endtask

  // Raster address of the n-th pixel of a frame, straight from the geometry.
  function automatic logic [AW-1:0] ref_addr(input int n);
    int mb, p, blk, px, py, bx, by, x, y;
    mb  = n / 256;
    p   = n % 256;
    blk = p / 16;
    py  = (p / 4) % 4;
    px  = p % 4;
    bx  = (blk % 2) + 2 * ((blk / 4) % 2);
    by  = ((blk / 2) % 2) + 2 * (blk / 8);
    x   = (mb % MBX) * 16 + bx * 4 + px;
    y   = (mb / MBX) * 16 + by * 4 + py;
    return AW'(y * FW + x);
  endfunction

  // driver tasks
  task automatic start_frame();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Streams pixels until the model leaves RUN, or until stop_at transfers.
  task automatic stream(input int gap_pct, input int stop_at);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < BUDGET) begin
      @(negedge clk);
      if (!m_run || (stop_at >= 0 && m_cnt == stop_at)) begin
        ok = 1'b1;
        break;
      end
      i_pix_valid = ($urandom_range(0, 99) >= gap_pct);
      i_pix_in    = PW'($urandom_range(0, 255));
      n++;
    end
    if (!ok) begin
      chk("stream_timeout", n, -1);
    end
  endtask

  task automatic model_thread();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0;
        m_cnt = 0;
        exp_q.delete();
      end else if (m_run) begin
        if (i_pix_valid) begin
          exp_q.push_back({ref_addr(m_cnt), i_pix_in,
                           1'((m_cnt % 256) == 255), 1'(m_cnt == NPIX - 1)});
          if (m_cnt == NPIX - 1) begin
            m_run = 1'b0;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
      end else if (i_start) begin
        m_run = 1'b1;
        m_cnt = 0;
      end
    end
  endtask

  // scoreboard: every negedge the DUT outputs are set against the model
  task automatic compare_thread();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hold_addr = '0;
        hold_data = '0;
        li        = 0;
        chk("rst_outputs", int'(o_pix_ready) + int'(o_wr_en) + int'(o_mb_done)
            + int'(o_frame_done) + int'(o_busy) + int'(o_wr_addr) + int'(o_wr_data), 0);
        continue;
      end
      chk("pix_ready", o_pix_ready, m_run);
      chk("busy", o_busy, m_run);
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", o_wr_addr, -1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", o_wr_addr, e[EW-1 -: AW]);
          chk("wr_data", o_wr_data, e[PW+1:2]);
          chk("mb_done", o_mb_done, e[1]);
          chk("frame_done", o_frame_done, e[0]);
          hold_addr = e[EW-1 -: AW];
          hold_data = e[PW+1:2];
        end
        if (lf < NFR) begin
          if (li == 0) first_cyc[lf] = cyc;
          if (li < NPIX) begin
            obs_addr[lf][li] = o_wr_addr;
            obs_mbd[lf][li]  = o_mb_done;
            obs_fd[lf][li]   = o_frame_done;
          end
          li++;
          if (o_frame_done) begin
            wr_cnt[lf]     = li;
            last_cyc[lf]   = cyc;
            busy_at_fd[lf] = o_busy;
            lf++;
            li = 0;
          end
        end
      end else begin
        chk("missing_write", exp_q.size(), 0);
        exp_q.delete();
        chk("hold_addr", o_wr_addr, hold_addr);
        chk("hold_data", o_wr_data, hold_data);
        chk("idle_flags", int'(o_mb_done) + int'(o_frame_done), 0);
      end
    end
  endtask

  initial begin
    int errs;
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_pix_valid = 1'b0;
    i_pix_in    = '0;
    for (int f = 0; f < NFR; f++) begin
      wr_cnt[f]     = 0;
      first_cyc[f]  = 0;
      last_cyc[f]   = 0;
      busy_at_fd[f] = 1'b1;
    end
    fork
      model_thread();
      compare_thread();
    join_none

    // pin the model to hand-computed addresses
    chk("model_p0", ref_addr(0), 0);
    chk("model_p16", ref_addr(16), 4);
    chk("model_p32", ref_addr(32), 128);
    chk("model_p255", ref_addr(255), 495);
    chk("model_mb1", ref_addr(256), 16);
    chk("model_mb2", ref_addr(512), 512);
    chk("model_last", ref_addr(1023), 1023);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // valid without start must not produce writes
    i_pix_valid = 1'b1;
    repeat (5) @(negedge clk);

    // frame 0: continuous
    start_frame();
    stream(0, -1);
    // frame 1: ~50% valid gaps
    start_frame();
    stream(50, -1);
    // frame 2: start pulsed at pidx 100 of MB1
    start_frame();
    stream(30, 356);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    stream(30, -1);

    // abandoned frame: async reset at pidx 40 of MB0
    start_frame();
    stream(0, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", int'(o_pix_ready) + int'(o_wr_en) + int'(o_mb_done)
        + int'(o_frame_done) + int'(o_busy) + int'(o_wr_addr) + int'(o_wr_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // frame 3: after reset
    start_frame();
    stream(0, -1);
    // frames 4 and 5: start in the frame_done cycle
    start_frame();
    stream(0, -1);
    i_start     = 1'b1;
    i_pix_valid = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    stream(0, -1);
    i_pix_valid = 1'b0;
    repeat (4) @(negedge clk);

    // literal expectations on the logged writes
    chk("f0_p0", obs_addr[0][0], 0);
    chk("f0_p16", obs_addr[0][16], 4);
    chk("f0_p32", obs_addr[0][32], 128);
    chk("f0_p255", obs_addr[0][255], 495);
    chk("f0_mbd255", obs_mbd[0][255], 1);
    chk("f0_mbd254", obs_mbd[0][254], 0);
    chk("f0_mb1", obs_addr[0][256], 16);
    chk("f0_mb2", obs_addr[0][512], 512);
    chk("f0_last", obs_addr[0][1023], 1023);
    chk("f0_last_flags", int'(obs_mbd[0][1023]) + int'(obs_fd[0][1023]), 2);
    chk("f0_busy_after", busy_at_fd[0], 0);
    chk("f3_first", obs_addr[3][0], 0);
    chk("f5_first", obs_addr[5][0], 0);
    chk("b2b_gap", first_cyc[5] - last_cyc[4], 2);
    for (int f = 0; f < NFR; f++) begin
      chk($sformatf("f%0d_writes", f), wr_cnt[f], NPIX);
      errs = 0;
      for (int i = 0; i < NPIX; i++) begin
        if (obs_addr[f][i] != ref_addr(i)) errs++;
      end
      chk($sformatf("f%0d_addr_seq", f), errs, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
